fifo_rd_packer: RTL and testbench
=================================

FIFO_RD_PACKER -- requirements
Module: fifo_rd_packer

Interface
REQ-001 SHALL have parameter DATA_SIZE, default 8, width of one FIFO read word (byte lane).
REQ-002 SHALL have parameter LANES, default 4, byte lanes per packed output word (legal 2..8).
REQ-003 SHALL have port r_clk  input  1  read-domain clock, all logic on rising edge.
REQ-004 SHALL have port r_rst  input  1  synchronous active-high reset.
REQ-005 SHALL have port r_empty  input  1  FIFO read-side empty flag.
REQ-006 SHALL have port r_en  output  1  FIFO read enable.
REQ-007 SHALL have port r_data  input  DATA_SIZE  FIFO read data, valid the cycle after r_en was high.
REQ-008 SHALL have port flush  input  1  request to emit a partially filled word.
REQ-009 SHALL have port out_data  output  LANES*DATA_SIZE  packed word.
REQ-010 SHALL have port out_keep  output  LANES  per-lane valid mask.
REQ-011 SHALL have port out_valid  output  1  out_data/out_keep valid.
REQ-012 SHALL have port out_ready  input  1  downstream accepts word when high with out_valid.
REQ-013 SHALL have port flush_done  output  1  one-cycle pulse at flush completion.
REQ-014 SHALL have port word_cnt  output  16  count of accepted output words.

Function
REQ-015 SHALL keep rd_pending (1 bit) = r_en registered; a byte SHALL be captured from r_data when rd_pending=1.
REQ-016 SHALL keep lane_cnt (0..LANES); captured byte SHALL go to lane lane_cnt (first byte in bits [DATA_SIZE-1:0]), then lane_cnt increments.
REQ-017 SHALL drive r_en = !r_empty && state==RUN && (lane_cnt + rd_pending < LANES), combinationally.
REQ-018 SHALL hold one output slot; slot is free when out_valid=0 or out_valid&&out_ready in the current cycle.
REQ-019 SHALL, when lane_cnt==LANES and slot free, load the accumulator into out_data, out_keep = all ones, set out_valid, and clear lane_cnt next cycle.
REQ-020 SHALL hold out_data, out_keep, out_valid stable while out_valid=1 and out_ready=0.
REQ-021 SHALL clear out_valid after an out_ready handshake unless a new word loads in the same cycle.
REQ-022 SHALL increment word_cnt by 1 on each out_valid&&out_ready cycle, wrapping 0xFFFF -> 0x0000.
REQ-023 SHALL implement states RUN and FLUSH; RUN -> FLUSH when flush=1; flush in FLUSH SHALL be ignored.
REQ-024 SHALL, in FLUSH, hold r_en=0 and still capture any pending byte.
REQ-025 SHALL leave FLUSH for RUN when rd_pending==0 and slot free; in that cycle: if lane_cnt>0, load word with lanes >= lane_cnt zeroed, out_keep bit i = (i < lane_cnt), clear lane_cnt; if lane_cnt==0 emit nothing; pulse flush_done.
REQ-026 SHALL ensure no byte is lost or duplicated under any out_ready/r_empty pattern.
REQ-027 SHALL sustain at least LANES bytes per LANES+2 cycles with out_ready=1 and r_empty=0.

Reset
REQ-028 SHALL, while r_rst=1 at a rising edge, set state=RUN, rd_pending=0, lane_cnt=0, out_valid=0, out_data=0, out_keep=0, flush_done=0, word_cnt=0.
REQ-029 SHALL drive r_en=0 in every cycle where r_rst=1.
REQ-030 SHALL discard any in-flight byte when reset occurs mid-operation; reset overrides a simultaneous flush.

Verification
REQ-031 SHALL pass: 8 bytes 0x00..0x07 in FIFO, out_ready=1 -> words 0x03020100 and 0x07060504, out_keep=0xF, word_cnt=2.
REQ-032 SHALL pass: 4 bytes 0xA0..0xA3, out_ready=0 for 20 cycles -> out_valid=1 held at 0xA3A2A1A0, r_en low once the next 4 bytes are in the accumulator or pending; releasing out_ready yields both words in order.
REQ-033 SHALL pass: 3 bytes 0x11,0x22,0x33, FIFO then empty, flush pulse -> out_data=0x00332211, out_keep=0x7, flush_done exactly once.
REQ-034 SHALL pass: flush with lane_cnt=0 and no pending read -> no out_valid, flush_done pulse within 2 cycles.
REQ-035 SHALL pass: r_rst asserted one cycle after an r_en with 2 bytes accumulated -> all outputs at reset values; after release, new bytes 0x40..0x43 pack to 0x43424140.
REQ-036 SHALL pass: random r_empty and out_ready for 10000 bytes (incrementing pattern) -> output stream equals input stream, word_cnt = 2500.

Source files
------------

// File: rtl/fifo_rd_packer_if.sv
// rtl/fifo_rd_packer_if.sv - FIFO read port and packed output stream bundle for fifo_rd_packer
interface fifo_rd_packer_if #(
    parameter int DATA_SIZE = 8,
    parameter int LANES     = 4
);
    logic                       r_empty;
    logic                       r_en;
    logic [DATA_SIZE-1:0]       r_data;
    logic [LANES*DATA_SIZE-1:0] out_data;
    logic [LANES-1:0]           out_keep;
    logic                       out_valid;
    logic                       out_ready;

    modport master (
        input  r_empty,
        input  r_data,
        input  out_ready,
        output r_en,
        output out_data,
        output out_keep,
        output out_valid
    );

    modport slave (
        output r_empty,
        output r_data,
        output out_ready,
        input  r_en,
        input  out_data,
        input  out_keep,
        input  out_valid
    );
endinterface

// File: rtl/fifo_rd_packer.sv
// rtl/fifo_rd_packer.sv - packs FIFO read bytes into LANES-wide words with flush of partial words
module fifo_rd_packer #(
    parameter int DATA_SIZE = 8,
    parameter int LANES     = 4
) (
    input  logic              r_clk,
    input  logic              r_rst,
    fifo_rd_packer_if.master  bus,
    input  logic              flush,
    output logic              flush_done,
    output logic [15:0]       word_cnt
);
    localparam int CW = $clog2(LANES + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(LANES);
    localparam logic [CW:0]   LANES_W  = (CW + 1)'(LANES);

    typedef enum logic {RUN, FLUSH} state_t;

    state_t                     state;
    logic                       rd_pending;
    logic [CW-1:0]              lane_cnt;
    logic [LANES*DATA_SIZE-1:0] acc;

    logic                       slot_free;
    logic                       handshake;
    logic                       load_full;
    logic                       flush_exit;
    logic                       load_word;
    logic [CW:0]                fill_level;
    logic [LANES-1:0]           keep_mask;
    logic [LANES*DATA_SIZE-1:0] packed_word;

    // A read may only be issued if its byte still has a lane once the pending one lands.
    assign fill_level = {1'b0, lane_cnt} + {{CW{1'b0}}, rd_pending};
    assign bus.r_en   = !r_rst && !bus.r_empty && (state == RUN) && (fill_level < LANES_W);

    always_comb begin
        slot_free   = !bus.out_valid || bus.out_ready;
        handshake   = bus.out_valid && bus.out_ready;
        load_full   = (state == RUN) && (lane_cnt == FULL_CNT) && slot_free;
        flush_exit  = (state == FLUSH) && !rd_pending && slot_free;
        load_word   = load_full || (flush_exit && (lane_cnt != '0));
        keep_mask   = '0;
        packed_word = '0;
        for (int i = 0; i < LANES; i++) begin
            keep_mask[i] = (CW'(i) < lane_cnt);
            if (keep_mask[i]) begin
                packed_word[i*DATA_SIZE +: DATA_SIZE] = acc[i*DATA_SIZE +: DATA_SIZE];
            end
        end
    end

    always_ff @(posedge r_clk) begin
        if (r_rst) begin
            state         <= RUN;
            rd_pending    <= 1'b0;
            lane_cnt      <= '0;
            acc           <= '0;
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_keep  <= '0;
            flush_done    <= 1'b0;
            word_cnt      <= 16'd0;
        end else begin
            rd_pending <= bus.r_en;
            flush_done <= flush_exit;

            if (handshake) begin
                word_cnt <= word_cnt + 16'd1;
            end

            // Loading only happens with no byte in flight, so capture and load never collide.
            if (load_word) begin
                bus.out_data  <= packed_word;
                bus.out_keep  <= keep_mask;
                bus.out_valid <= 1'b1;
                lane_cnt      <= '0;
            end else begin
                if (handshake) begin
                    bus.out_valid <= 1'b0;
                end
                if (flush_exit) begin
                    lane_cnt <= '0;
                end else if (rd_pending) begin
                    lane_cnt <= lane_cnt + 1'b1;
                end
            end

            for (int i = 0; i < LANES; i++) begin
                if (rd_pending && !load_word && (lane_cnt == CW'(i))) begin
                    acc[i*DATA_SIZE +: DATA_SIZE] <= bus.r_data;
                end
            end

            case (state)
                RUN:     if (flush) state <= FLUSH;
                FLUSH:   if (flush_exit) state <= RUN;
                default: state <= RUN;
            endcase
        end
    end
endmodule

// File: tb/tb_fifo_rd_packer.sv
// tb/tb_fifo_rd_packer.sv - directed and randomized-handshake checks for fifo_rd_packer
module tb_fifo_rd_packer;
    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        flush_done;
    logic [15:0] word_cnt;

    fifo_rd_packer_if #(.DATA_SIZE(8), .LANES(4)) bus ();

    fifo_rd_packer #(.DATA_SIZE(8), .LANES(4)) dut (
        .r_clk      (clk),
        .r_rst      (rst),
        .bus        (bus),
        .flush      (flush),
        .flush_done (flush_done),
        .word_cnt   (word_cnt)
    );

    always #5 clk = ~clk;

    int          n_assert = 0;
    int          n_fail   = 0;
    logic [7:0]  fifo_q[$];
    logic [31:0] out_q[$];
    logic [3:0]  keep_q[$];
    logic [7:0]  next_byte = 8'h00;
    bit          have_next = 0;
    bit          rand_mode = 0;
    bit          empty_gate = 0;
    bit          hold_armed = 0;
    logic [31:0] held_data;
    logic [3:0]  held_keep;
    int          unstable = 0;
    int          underflow = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: FIFO model answers r_en at the negedge, outputs are sampled there too.
    task automatic step();
        if (rand_mode) begin
            bus.out_ready = ($urandom_range(99) < 75);
            empty_gate    = ($urandom_range(99) < 25);
        end
        @(negedge clk);
        if (have_next) bus.r_data = next_byte;
        bus.r_empty = (fifo_q.size() == 0) || empty_gate;
        #1;
        if (bus.r_en === 1'b1) begin
            if (fifo_q.size() == 0) underflow++;
            else next_byte = fifo_q.pop_front();
            have_next = 1;
        end else begin
            have_next = 0;
        end
        if (hold_armed && (bus.out_valid !== 1'b1 || bus.out_data !== held_data || bus.out_keep !== held_keep))
            unstable++;
        hold_armed = (bus.out_valid === 1'b1) && (bus.out_ready === 1'b0);
        held_data  = bus.out_data;
        held_keep  = bus.out_keep;
        if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            out_q.push_back(bus.out_data);
            keep_q.push_back(bus.out_keep);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_words(input int n, input int budget);
        for (int k = 0; k < budget && out_q.size() < n; k++) step();
    endtask

    initial begin
        int          fd_cnt;
        bit          any_valid;
        int          errs;
        int          kerrs;
        logic [31:0] w;

        rst = 1'b1;
        flush = 1'b0;
        bus.r_empty = 1'b1;
        bus.r_data = 8'h00;
        bus.out_ready = 1'b1;

        // Reset with data waiting in the FIFO
        for (int i = 0; i < 8; i++) fifo_q.push_back(8'(i));
        repeat (3) step();
        chk("reset_r_en", {63'd0, bus.r_en}, 64'd0);
        chk("reset_out_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("reset_out_data", {32'd0, bus.out_data}, 64'd0);
        chk("reset_out_keep", {60'd0, bus.out_keep}, 64'd0);
        chk("reset_flush_done", {63'd0, flush_done}, 64'd0);
        chk("reset_word_cnt", {48'd0, word_cnt}, 64'd0);
        rst = 1'b0;

        // Two full words with out_ready held high
        wait_words(2, 40);
        repeat (2) step();
        chk("basic_words", out_q.size(), 2);
        chk("basic_w0", {32'd0, out_q[0]}, 64'h03020100);
        chk("basic_w1", {32'd0, out_q[1]}, 64'h07060504);
        chk("basic_keep0", {60'd0, keep_q[0]}, 64'hF);
        chk("basic_keep1", {60'd0, keep_q[1]}, 64'hF);
        chk("basic_word_cnt", {48'd0, word_cnt}, 64'd2);

        // Backpressure: one word held, next word staged, reads stop
        out_q.delete(); keep_q.delete();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 12; i++) fifo_q.push_back(8'hA0 + 8'(i));
        repeat (20) step();
        chk("bp_out_valid", {63'd0, bus.out_valid}, 64'd1);
        chk("bp_out_data", {32'd0, bus.out_data}, 64'hA3A2A1A0);
        chk("bp_r_empty", {63'd0, bus.r_empty}, 64'd0);
        chk("bp_r_en", {63'd0, bus.r_en}, 64'd0);
        chk("bp_fifo_left", fifo_q.size(), 4);
        chk("bp_no_words", out_q.size(), 0);
        bus.out_ready = 1'b1;
        wait_words(3, 40);
        repeat (2) step();
        chk("bp_words", out_q.size(), 3);
        chk("bp_w0", {32'd0, out_q[0]}, 64'hA3A2A1A0);
        chk("bp_w1", {32'd0, out_q[1]}, 64'hA7A6A5A4);
        chk("bp_w2", {32'd0, out_q[2]}, 64'hABAAA9A8);
        chk("bp_word_cnt", {48'd0, word_cnt}, 64'd5);
        chk("bp_hold_stable", unstable, 0);

        // Partial word flush
        out_q.delete(); keep_q.delete();
        fifo_q.push_back(8'h11); fifo_q.push_back(8'h22); fifo_q.push_back(8'h33);
        repeat (10) step();
        chk("pf_no_early_word", out_q.size(), 0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        fd_cnt = int'(flush_done);
        for (int k = 0; k < 10; k++) begin
            step();
            fd_cnt += int'(flush_done);
        end
        chk("pf_words", out_q.size(), 1);
        chk("pf_data", {32'd0, out_q[0]}, 64'h00332211);
        chk("pf_keep", {60'd0, keep_q[0]}, 64'h7);
        chk("pf_flush_done_once", fd_cnt, 1);
        chk("pf_word_cnt", {48'd0, word_cnt}, 64'd6);

        // Flush with nothing accumulated
        out_q.delete(); keep_q.delete();
        flush = 1'b1;
        step();
        flush = 1'b0;
        fd_cnt = int'(flush_done);
        any_valid = bus.out_valid;
        for (int k = 0; k < 2; k++) begin
            step();
            fd_cnt += int'(flush_done);
            any_valid |= bus.out_valid;
        end
        chk("ef_flush_done", fd_cnt, 1);
        chk("ef_no_valid", {63'd0, any_valid}, 64'd0);
        chk("ef_word_cnt", {48'd0, word_cnt}, 64'd6);

        // Reset with 2 bytes accumulated and a read in flight, flush raised alongside
        fifo_q.push_back(8'h90); fifo_q.push_back(8'h91); fifo_q.push_back(8'h92);
        repeat (3) step();
        rst = 1'b1;
        flush = 1'b1;
        repeat (2) step();
        flush = 1'b0;
        chk("mr_out_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("mr_out_data", {32'd0, bus.out_data}, 64'd0);
        chk("mr_out_keep", {60'd0, bus.out_keep}, 64'd0);
        chk("mr_word_cnt", {48'd0, word_cnt}, 64'd0);
        chk("mr_flush_done", {63'd0, flush_done}, 64'd0);
        chk("mr_r_en", {63'd0, bus.r_en}, 64'd0);
        rst = 1'b0;
        out_q.delete(); keep_q.delete();
        for (int i = 0; i < 4; i++) fifo_q.push_back(8'h40 + 8'(i));
        wait_words(1, 30);
        repeat (2) step();
        chk("mr_words", out_q.size(), 1);
        chk("mr_data", {32'd0, out_q[0]}, 64'h43424140);
        chk("mr_keep", {60'd0, keep_q[0]}, 64'hF);
        chk("mr_word_cnt_after", {48'd0, word_cnt}, 64'd1);

        // Random empty/ready stream of 10000 bytes
        rst = 1'b1;
        repeat (2) step();
        rst = 1'b0;
        out_q.delete(); keep_q.delete();
        unstable = 0;
        for (int i = 0; i < 10000; i++) fifo_q.push_back(8'(i));
        rand_mode = 1;
        wait_words(2500, 80000);
        rand_mode = 0;
        empty_gate = 0;
        bus.out_ready = 1'b1;
        repeat (10) step();
        errs = 0;
        kerrs = 0;
        for (int wi = 0; wi < out_q.size(); wi++) begin
            w = out_q[wi];
            if (keep_q[wi] !== 4'hF) kerrs++;
            for (int b = 0; b < 4; b++)
                if (w[b*8 +: 8] !== 8'(wi*4 + b)) errs++;
        end
        chk("rnd_words", out_q.size(), 2500);
        chk("rnd_byte_errors", errs, 0);
        chk("rnd_keep_errors", kerrs, 0);
        chk("rnd_word_cnt", {48'd0, word_cnt}, 64'd2500);
        chk("rnd_fifo_drained", fifo_q.size(), 0);
        chk("rnd_hold_stable", unstable, 0);
        chk("rnd_underflow", underflow, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
